// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - byte-stream loadable instruction memory with bounds-checked fetch
module program_memory_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [BYTE_WIDTH-1:0] ld_byte,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ld_trunc,
  output logic                  ready,
  output logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  fault
);

  localparam int BPW   = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] word_acc;
  logic [CNT_W-1:0]      byte_cnt;
  logic [ADDR_WIDTH-1:0] wptr;
  logic                  accept;
  logic                  word_done;
  logic                  at_top;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] wr_word;

  // A short final word is left-justified so unused low bytes read as zero.
  always_comb begin
    accept    = (state == LOAD) && ld_ready && ld_valid && !ld_start;
    shifted   = (word_acc << BYTE_WIDTH) | DATA_WIDTH'(ld_byte);
    word_done = accept && (ld_last || (byte_cnt == CNT_W'(BPW - 1)));
    wr_word   = shifted << (BYTE_WIDTH * (BPW - 1 - int'(byte_cnt)));
    at_top    = (wptr == {ADDR_WIDTH{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (word_done && !rst) begin
      mem[wptr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_ready   <= 1'b0;
      ld_trunc   <= 1'b0;
      ready      <= 1'b0;
      prog_len   <= '0;
      wptr       <= '0;
      byte_cnt   <= '0;
      word_acc   <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      fault      <= 1'b0;
      // A new load takes priority in every state, dropping any same-cycle fetch.
      if (ld_start) begin
        state    <= LOAD;
        ld_ready <= 1'b1;
        ready    <= 1'b0;
        ld_trunc <= 1'b0;
        prog_len <= '0;
        wptr     <= '0;
        byte_cnt <= '0;
        word_acc <= '0;
      end else begin
        case (state)
          LOAD: begin
            if (word_done) begin
              wptr     <= wptr + 1'b1;
              prog_len <= prog_len + 1'b1;
              byte_cnt <= '0;
              word_acc <= '0;
              if (ld_last || at_top) begin
                state    <= RUN;
                ld_ready <= 1'b0;
                ready    <= 1'b1;
                ld_trunc <= !ld_last;
              end
            end else if (accept) begin
              byte_cnt <= byte_cnt + 1'b1;
              word_acc <= shifted;
            end
          end
          RUN: begin
            if (fetch_en) begin
              if ({1'b0, fetch_addr} < prog_len) begin
                data       <= mem[fetch_addr];
                data_valid <= 1'b1;
              end else begin
                data  <= '0;
                fault <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// tb/tb_program_memory_loader.sv - directed-vector bench for program_memory_loader
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start, ld_valid, ld_last, fetch_en;
  logic [7:0]  ld_byte;
  logic [10:0] fetch_addr;

  logic        ld_ready0, ld_trunc0, ready0, dv0, fault0;
  logic [11:0] prog_len0;
  logic [15:0] data0;
  logic        ld_ready1, ld_trunc1, ready1, dv1, fault1;
  logic [2:0]  prog_len1;
  logic [15:0] data1;
  logic        ld_ready2, ld_trunc2, ready2, dv2, fault2;
  logic [11:0] prog_len2;
  logic [23:0] data2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  program_memory_loader u0 (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready0), .ld_trunc(ld_trunc0), .ready(ready0),
    .prog_len(prog_len0), .fetch_en(fetch_en), .fetch_addr(fetch_addr), .data(data0),
    .data_valid(dv0), .fault(fault0)
  );

  program_memory_loader #(.ADDR_WIDTH(2)) u1 (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready1), .ld_trunc(ld_trunc1), .ready(ready1),
    .prog_len(prog_len1), .fetch_en(fetch_en), .fetch_addr(fetch_addr[1:0]), .data(data1),
    .data_valid(dv1), .fault(fault1)
  );

  program_memory_loader #(.DATA_WIDTH(24)) u2 (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready2), .ld_trunc(ld_trunc2), .ready(ready2),
    .prog_len(prog_len2), .fetch_en(fetch_en), .fetch_addr(fetch_addr), .data(data2),
    .data_valid(dv2), .fault(fault2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int gap);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic fetch(input logic [10:0] addr);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    @(negedge clk);
    fetch_en   = 1'b0;
  endtask

  task automatic fetch0(input string tag, input logic [10:0] addr, input logic [15:0] exp_data,
                        input logic exp_dv, input logic exp_fault);
    fetch(addr);
    check({tag, "_data"}, data0, exp_data);
    check({tag, "_dv"}, dv0, exp_dv);
    check({tag, "_fault"}, fault0, exp_fault);
  endtask

  logic [7:0] basic_prog [8] = '{8'h18, 8'h04, 8'h08, 8'h01, 8'h18, 8'h02, 8'h00, 8'h00};
  logic [15:0] basic_exp [4] = '{16'h1804, 16'h0801, 16'h1802, 16'h0000};

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = '0;
    fetch_en = 1'b0; fetch_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ld_ready", ld_ready0, 0);
    check("rst_ld_trunc", ld_trunc0, 0);
    check("rst_ready", ready0, 0);
    check("rst_prog_len", prog_len0, 0);
    check("rst_data", data0, 0);
    check("rst_dv", dv0, 0);
    check("rst_fault", fault0, 0);
    fetch0("idle_fetch", 0, 16'h0000, 0, 0);

    // basic load and fetch
    start_load();
    check("load_ld_ready", ld_ready0, 1);
    check("load_ready", ready0, 0);
    for (int i = 0; i < 8; i++) send(basic_prog[i], i == 7, 0);
    check("basic_ready", ready0, 1);
    check("basic_ld_ready", ld_ready0, 0);
    check("basic_prog_len", prog_len0, 4);
    check("basic_trunc", ld_trunc0, 0);
    for (int i = 0; i < 4; i++) fetch0($sformatf("basic_f%0d", i), 11'(i), basic_exp[i], 1, 0);
    fetch0("basic_oob", 4, 16'h0000, 0, 1);
    @(negedge clk);
    check("fault_pulse", fault0, 0);
    fetch0("basic_f2b", 2, 16'h1802, 1, 0);
    @(negedge clk);
    check("hold_data", data0, 16'h1802);
    check("hold_dv", dv0, 0);

    // reload from RUN with a simultaneous fetch
    ld_start = 1'b1; fetch_en = 1'b1; fetch_addr = 0;
    @(negedge clk);
    ld_start = 1'b0; fetch_en = 1'b0;
    check("reload_dv", dv0, 0);
    check("reload_data_held", data0, 16'h1802);
    check("reload_ready", ready0, 0);
    check("reload_prog_len", prog_len0, 0);
    check("reload_ld_ready", ld_ready0, 1);
    send(8'h00, 0, 0);
    send(8'h00, 1, 0);
    check("reload_len1", prog_len0, 1);
    check("reload_ready1", ready0, 1);
    fetch0("reload_f0", 0, 16'h0000, 1, 0);
    fetch0("reload_f1", 1, 16'h0000, 0, 1);

    // partial-word padding, back to back then with gaps
    for (int g = 0; g <= 3; g += 3) begin
      start_load();
      send(8'h20, 0, g);
      send(8'h01, 0, g);
      send(8'h30, 1, g);
      check($sformatf("pad_len_g%0d", g), prog_len0, 2);
      fetch0($sformatf("pad_f0_g%0d", g), 0, 16'h2001, 1, 0);
      fetch0($sformatf("pad_f1_g%0d", g), 1, 16'h3000, 1, 0);
    end

    // reset in the middle of a load
    start_load();
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    send(8'h33, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", ready0, 0);
    check("mid_rst_len", prog_len0, 0);
    check("mid_rst_ld_ready", ld_ready0, 0);
    fetch0("mid_rst_fetch", 0, 16'h0000, 0, 0);
    send(8'h99, 1, 0);
    check("mid_rst_no_accept", prog_len0, 0);
    start_load();
    send(8'h44, 0, 0);
    send(8'h55, 1, 0);
    check("after_rst_len", prog_len0, 1);
    fetch0("after_rst_f0", 0, 16'h4455, 1, 0);

    // overflow on the 4-word instance
    start_load();
    for (int i = 1; i <= 8; i++) send(8'(i), 0, 0);
    check("ovf_len", prog_len1, 4);
    check("ovf_trunc", ld_trunc1, 1);
    check("ovf_ready", ready1, 1);
    check("ovf_ld_ready", ld_ready1, 0);
    send(8'h09, 0, 0);
    send(8'h0A, 0, 0);
    check("ovf_len_after", prog_len1, 4);
    check("ovf_ld_ready_after", ld_ready1, 0);
    fetch(0);
    check("ovf_f0", data1, 16'h0102);
    fetch(3);
    check("ovf_f3", data1, 16'h0708);
    check("ovf_f3_dv", dv1, 1);
    start_load();
    check("ovf_trunc_clr", ld_trunc1, 0);

    // 24-bit words
    send(8'hAA, 0, 0);
    send(8'hBB, 0, 0);
    send(8'hCC, 1, 0);
    check("w24_len", prog_len2, 1);
    fetch(0);
    check("w24_f0", data2, 24'hAABBCC);
    check("w24_dv", dv2, 1);
    check("w24_fault", fault2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_memory_loader.md
# program_memory_loader

Parametrised, loadable instruction memory for the BIP core. Replaces fixed reset-time program initialisation with a byte-stream loader: the program arrives from a host link, such as a UART receiver, as a sequence of bytes. Completed words are written into a DEPTH-word store. The block then serves single-cycle-latency instruction fetches from the CPU, with bounds checking against the loaded program length.

## Interface
- DATA_WIDTH, 16, instruction word width; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 11, fetch/write address width; DEPTH = 2**ADDR_WIDTH words
- BYTE_WIDTH, 8, loader bus width; BPW = DATA_WIDTH/BYTE_WIDTH bytes per word
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- ld_start  in  1  pulse: begin a new program load
- ld_valid  in  1  ld_byte valid this cycle
- ld_byte  in  BYTE_WIDTH  program byte, most-significant byte of each word first
- ld_last  in  1  qualifies ld_byte as final byte of the program
- ld_ready  out  1  loader accepts a byte (high only in LOAD)
- ld_trunc  out  1  sticky: load stopped because memory filled
- ready  out  1  program loaded; CPU may fetch (high only in RUN)
- prog_len  out  ADDR_WIDTH+1  number of words loaded
- fetch_en  in  1  fetch request
- fetch_addr  in  ADDR_WIDTH  instruction address
- data  out  DATA_WIDTH  fetched instruction
- data_valid  out  1  data holds a valid in-range fetch result
- fault  out  1  one-cycle pulse: fetch address >= prog_len

## Operation
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- Reset values: ld_ready=0, ld_trunc=0, ready=0, prog_len=0, data=0, data_valid=0, fault=0, byte counter=0, write pointer=0. Memory contents are not cleared.
- IDLE→LOAD, RUN→LOAD, and LOAD→LOAD (restart) on ld_start.
  - Each of these clears prog_len, the write pointer, the byte counter, the word assembly register and ld_trunc.
  - A byte presented in the same cycle as ld_start is not accepted.
- LOAD byte handling:
  - Byte accepted when ld_valid && ld_ready. Bytes are shifted into the assembly register MSB-first.
  - On the BPW-th byte, the assembled word is written to mem[wptr]; wptr and prog_len increment.
- LOAD end conditions:
  - ld_last on an accepted byte that completes a word: write the word, go to RUN.
  - ld_last on a partial word: pad the remaining low bytes with zero, write the word, prog_len+1, go to RUN.
  - A write to address DEPTH-1 without ld_last: go to RUN, set ld_trunc=1, ignore further bytes (ld_ready=0).
- RUN fetch handling (fetch_en=1):
  - fetch_addr < prog_len: data=mem[fetch_addr], data_valid=1.
  - Otherwise: data=0 (HALT encoding), data_valid=0, fault=1.
- fetch_en=0, or any state other than RUN: data holds its last value, data_valid=0, fault=0.
- ld_start with fetch_en in the same cycle while in RUN: the load wins and the fetch is dropped (data_valid=0 next cycle).
- prog_len ranges over 0..DEPTH, hence the extra bit.

## Timing
- ld_ready and ready are registered decodes of state. They change on the cycle after the transition edge.
- The word write happens on the edge that accepts its final byte. ready=1 starting on the next cycle.
- Fetch latency is 1 cycle: request at edge N produces data, data_valid and fault during cycle N+1. Back-to-back fetches are supported every cycle.
- No read/write collision is possible: writes occur only in LOAD and reads only in RUN.
- Reset mid-LOAD: the next state is IDLE, the partial word is discarded, prog_len=0, and ready stays 0 until a complete load.
- Gaps (ld_valid=0) between bytes are allowed with no timeout.

## Test plan
- Basic load and fetch:
  - Stimulus: ld_start, then bytes 18 04 08 01 18 02 00 00 with ld_last on the final byte.
  - Response: prog_len=4, ready=1. Fetches of addresses 0..3 return 0x1804, 0x0801, 0x1802, 0x0000, each with data_valid=1 one cycle later.
  - A fetch of address 4 gives data=0, fault=1, data_valid=0.
- Partial-word padding:
  - Stimulus: bytes 20 01 30 with ld_last on 30.
  - Response: prog_len=2, fetch of address 1 returns 0x3000.
  - Stimulus: ld_valid gaps of 3 cycles between bytes.
  - Response: same result.
- Reset mid-load:
  - Stimulus: rst after 3 bytes.
  - Response: IDLE, ready=0, prog_len=0, ld_ready=0. Fetch requests produce data_valid=0 and fault=0.
- Reload from RUN:
  - Stimulus: after the basic load, ld_start together with fetch_en.
  - Response: fetch dropped, ready=0, prog_len=0. A new 2-byte program 00 00 gives prog_len=1.
- Overflow (ADDR_WIDTH=2):
  - Stimulus: 10 bytes streamed with no ld_last.
  - Response: after the 8th byte, RUN with prog_len=4 and ld_trunc=1; the 9th and 10th bytes are not accepted (ld_ready=0).
- Width parameterisation (DATA_WIDTH=24):
  - Stimulus: bytes AA BB CC with ld_last.
  - Response: fetch of address 0 returns 0xAABBCC.
